// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state TMS sequencer with registered capture/shift/update
// strobes, TDO mux and a saturating shift-cycle counter.
module tap_controller #(
    parameter int DR_CNT_W = 8
) (
    input  logic                TCK,
    input  logic                TRST_N,
    input  logic                TMS,
    input  logic                dr_tdo,
    input  logic                ir_tdo,
    output logic                TDO,
    output logic                tdo_en,
    output logic [3:0]          state,
    output logic                tlr,
    output logic                capturedr,
    output logic                shiftdr,
    output logic                clockdr,
    output logic                updatedr,
    output logic                captureir,
    output logic                shiftir,
    output logic                updateir,
    output logic [DR_CNT_W-1:0] shift_cnt
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_e;

    tap_state_e          state_r;
    tap_state_e          next_state_s;
    logic                tdo_en_r;
    logic                tlr_r;
    logic                capturedr_r;
    logic                shiftdr_r;
    logic                clockdr_r;
    logic                updatedr_r;
    logic                captureir_r;
    logic                shiftir_r;
    logic                updateir_r;
    logic [DR_CNT_W-1:0] shift_cnt_r;

    // TAP state register
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state_r <= TLR;
        end else begin
            state_r <= next_state_s;
        end
    end

    // TMS-driven next-state decode
    always_comb begin
        next_state_s = TLR;
        case (state_r)
            TLR:     next_state_s = TMS ? TLR    : RTI;
            RTI:     next_state_s = TMS ? SEL_DR : RTI;
            SEL_DR:  next_state_s = TMS ? SEL_IR : CAP_DR;
            CAP_DR:  next_state_s = TMS ? EX1_DR : SH_DR;
            SH_DR:   next_state_s = TMS ? EX1_DR : SH_DR;
            EX1_DR:  next_state_s = TMS ? UPD_DR : PAU_DR;
            PAU_DR:  next_state_s = TMS ? EX2_DR : PAU_DR;
            EX2_DR:  next_state_s = TMS ? UPD_DR : SH_DR;
            UPD_DR:  next_state_s = TMS ? SEL_DR : RTI;
            SEL_IR:  next_state_s = TMS ? TLR    : CAP_IR;
            CAP_IR:  next_state_s = TMS ? EX1_IR : SH_IR;
            SH_IR:   next_state_s = TMS ? EX1_IR : SH_IR;
            EX1_IR:  next_state_s = TMS ? UPD_IR : PAU_IR;
            PAU_IR:  next_state_s = TMS ? EX2_IR : PAU_IR;
            EX2_IR:  next_state_s = TMS ? UPD_IR : SH_IR;
            UPD_IR:  next_state_s = TMS ? SEL_DR : RTI;
            default: next_state_s = TLR;
        endcase
    end

    // Strobes decoded from next state into flops so they align with the state and never glitch
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            tlr_r       <= 1'b1;
            tdo_en_r    <= 1'b0;
            capturedr_r <= 1'b0;
            shiftdr_r   <= 1'b0;
            clockdr_r   <= 1'b0;
            updatedr_r  <= 1'b0;
            captureir_r <= 1'b0;
            shiftir_r   <= 1'b0;
            updateir_r  <= 1'b0;
        end else begin
            tlr_r       <= (next_state_s == TLR);
            tdo_en_r    <= (next_state_s == SH_DR) || (next_state_s == SH_IR);
            capturedr_r <= (next_state_s == CAP_DR);
            shiftdr_r   <= (next_state_s == SH_DR);
            clockdr_r   <= (next_state_s == CAP_DR) || (next_state_s == SH_DR);
            updatedr_r  <= (next_state_s == UPD_DR);
            captureir_r <= (next_state_s == CAP_IR);
            shiftir_r   <= (next_state_s == SH_IR);
            updateir_r  <= (next_state_s == UPD_IR);
        end
    end

    // Shift counter: cleared on entry to capture/reset, bumped on every edge out of a shift cycle
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            shift_cnt_r <= {DR_CNT_W{1'b0}};
        end else if ((next_state_s == CAP_DR) || (next_state_s == CAP_IR) ||
                     (next_state_s == TLR)) begin
            shift_cnt_r <= {DR_CNT_W{1'b0}};
        end else if (((state_r == SH_DR) || (state_r == SH_IR)) &&
                     (shift_cnt_r != {DR_CNT_W{1'b1}})) begin
            shift_cnt_r <= shift_cnt_r + DR_CNT_W'(1);
        end else begin
            shift_cnt_r <= shift_cnt_r;
        end
    end

    // Serial output mux follows the registered state only
    always_comb begin
        TDO = 1'b0;
        if (state_r == SH_IR) begin
            TDO = ir_tdo;
        end else if (state_r == SH_DR) begin
            TDO = dr_tdo;
        end else begin
            TDO = 1'b0;
        end
    end

    assign state     = state_r;
    assign tdo_en    = tdo_en_r;
    assign tlr       = tlr_r;
    assign capturedr = capturedr_r;
    assign shiftdr   = shiftdr_r;
    assign clockdr   = clockdr_r;
    assign updatedr  = updatedr_r;
    assign captureir = captureir_r;
    assign shiftir   = shiftir_r;
    assign updateir  = updateir_r;
    assign shift_cnt = shift_cnt_r;

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller: reset, DR/IR scans, pause/resume and counter saturation
// on an 8-bit and a 3-bit counter instance driven by the same TMS sequence.
module tb_tap_controller;

    logic       TCK = 1'b0;
    logic       TRST_N = 1'b0;
    logic       TMS = 1'b1;
    logic       dr_tdo = 1'b0;
    logic       ir_tdo = 1'b0;

    logic       TDO, tdo_en, tlr, capturedr, shiftdr, clockdr, updatedr;
    logic       captureir, shiftir, updateir;
    logic [3:0] state;
    logic [7:0] shift_cnt;

    logic       TDO3, tdo_en3, tlr3, capturedr3, shiftdr3, clockdr3, updatedr3;
    logic       captureir3, shiftir3, updateir3;
    logic [3:0] state3;
    logic [2:0] shift_cnt3;

    int n_tests = 0;
    int n_fail  = 0;

    tap_controller #(.DR_CNT_W(8)) u_dut (
        .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .dr_tdo(dr_tdo), .ir_tdo(ir_tdo),
        .TDO(TDO), .tdo_en(tdo_en), .state(state), .tlr(tlr),
        .capturedr(capturedr), .shiftdr(shiftdr), .clockdr(clockdr), .updatedr(updatedr),
        .captureir(captureir), .shiftir(shiftir), .updateir(updateir), .shift_cnt(shift_cnt)
    );

    tap_controller #(.DR_CNT_W(3)) u_dut3 (
        .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .dr_tdo(dr_tdo), .ir_tdo(ir_tdo),
        .TDO(TDO3), .tdo_en(tdo_en3), .state(state3), .tlr(tlr3),
        .capturedr(capturedr3), .shiftdr(shiftdr3), .clockdr(clockdr3), .updatedr(updatedr3),
        .captureir(captureir3), .shiftir(shiftir3), .updateir(updateir3), .shift_cnt(shift_cnt3)
    );

    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic tms);
        @(negedge TCK);
        TMS = tms;
        @(posedge TCK);
        #1;
    endtask

    // strobe vector: {tdo_en,tlr,capdr,shdr,clkdr,upddr,capir,shir,updir,TDO}
    function automatic logic [9:0] strobes3();
        return {tdo_en3, tlr3, capturedr3, shiftdr3, clockdr3, updatedr3,
                captureir3, shiftir3, updateir3, TDO3};
    endfunction

    initial begin
        // reset state
        repeat (2) @(posedge TCK);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_tlr", 32'(tlr), 32'd1);
        check("rst_strobes", 32'({tdo_en, capturedr, shiftdr, clockdr, updatedr,
                                  captureir, shiftir, updateir, TDO}), 32'd0);
        check("rst_cnt", 32'(shift_cnt), 32'd0);
        @(negedge TCK);
        TRST_N = 1'b1;

        // DR path: TLR -> RTI -> SEL_DR -> CAP_DR -> SH_DR
        step(1'b0); check("dr_rti", 32'(state), 32'd1);
        check("dr_rti_tlr", 32'(tlr), 32'd0);
        step(1'b1); check("dr_seldr", 32'(state), 32'd2);
        step(1'b0); check("dr_capdr", 32'(state), 32'd3);
        check("dr_cap_strb", 32'({capturedr, clockdr, shiftdr, tdo_en}), 32'b1100);
        step(1'b0); check("dr_shdr", 32'(state), 32'd4);
        check("dr_sh_strb", 32'({capturedr, clockdr, shiftdr, tdo_en}), 32'b0111);
        check("dr_sh_cnt", 32'(shift_cnt), 32'd0);
        dr_tdo = 1'b1; ir_tdo = 1'b0; #1;
        check("dr_tdo1", 32'(TDO), 32'd1);
        dr_tdo = 1'b0; ir_tdo = 1'b1; #1;
        check("dr_tdo0", 32'(TDO), 32'd0);

        // reset mid-scan
        step(1'b0); check("mid_cnt1", 32'(shift_cnt), 32'd1);
        step(1'b0); check("mid_cnt2", 32'(shift_cnt), 32'd2);
        #2; TRST_N = 1'b0; #1;
        check("mid_state", 32'(state), 32'd0);
        check("mid_tlr", 32'(tlr), 32'd1);
        check("mid_shiftdr", 32'(shiftdr), 32'd0);
        check("mid_cnt", 32'(shift_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check("mid_noupd", 32'({updatedr, state}), 32'd0);
        end
        @(negedge TCK);
        TRST_N = 1'b1;

        // IR load: from RTI, TMS 1,1,0,0,0,1,1
        ir_tdo = 1'b1; dr_tdo = 1'b0;
        step(1'b0); check("ir_rti", 32'(state), 32'd1);
        step(1'b1); check("ir_seldr", 32'(state), 32'd2);
        step(1'b1); check("ir_selir", 32'(state), 32'd9);
        step(1'b0); check("ir_capir", 32'({state, captureir}), {27'd0, 4'd10, 1'b1});
        step(1'b0); check("ir_sh1", 32'({state, shiftir, tdo_en, TDO}), {25'd0, 4'd11, 3'b111});
        step(1'b0); check("ir_sh2", 32'({state, shiftir, shift_cnt}), {19'd0, 4'd11, 1'b1, 8'd1});
        step(1'b1); check("ir_ex1", 32'({state, shiftir, shift_cnt}), {19'd0, 4'd12, 1'b0, 8'd2});
        check("ir_ex1_tdo", 32'(TDO), 32'd0);
        step(1'b1); check("ir_upd", 32'({state, updateir}), {27'd0, 4'd15, 1'b1});
        step(1'b0); check("ir_after", 32'({state, updateir, shift_cnt}), {19'd0, 4'd1, 1'b0, 8'd2});

        // TMS=1 x5 from PAU_IR returns to TLR
        step(1'b1); step(1'b1); step(1'b0); step(1'b0);
        step(1'b1); step(1'b0);
        check("pau_ir", 32'(state), 32'd13);
        step(1'b1); step(1'b1); step(1'b1); step(1'b1);
        check("sync4", 32'({state, tlr}), {27'd0, 4'd9, 1'b0});
        step(1'b1);
        check("sync5", 32'({state, tlr, shift_cnt}), {19'd0, 4'd0, 1'b1, 8'd0});

        // pause/resume in the DR scan
        step(1'b0); step(1'b1); step(1'b0); step(1'b0);
        check("pr_sh", 32'({state, shift_cnt}), {20'd0, 4'd4, 8'd0});
        step(1'b0); step(1'b0);
        check("pr_cnt2", 32'(shift_cnt), 32'd2);
        step(1'b1); check("pr_ex1", 32'({state, shiftdr, shift_cnt}), {19'd0, 4'd5, 1'b0, 8'd3});
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check("pr_pause", 32'({state, shiftdr, shift_cnt}), {19'd0, 4'd6, 1'b0, 8'd3});
        end
        step(1'b1); check("pr_ex2", 32'({state, shift_cnt}), {20'd0, 4'd7, 8'd3});
        step(1'b0); check("pr_resh", 32'({state, shiftdr, shift_cnt}), {19'd0, 4'd4, 1'b1, 8'd3});
        step(1'b0); check("pr_cnt4", 32'(shift_cnt), 32'd4);
        step(1'b0); check("pr_cnt5", 32'(shift_cnt), 32'd5);
        check("pr_cnt5_w3", 32'(shift_cnt3), 32'd5);

        // finish scan with an update, then saturate the 3-bit counter
        step(1'b1); check("sat_ex1", 32'(shift_cnt3), 32'd6);
        step(1'b1); check("sat_upd", 32'({state, updatedr}), {27'd0, 4'd8, 1'b1});
        step(1'b1); step(1'b0);
        check("sat_cap", 32'({state3, shift_cnt3}), {25'd0, 4'd3, 3'd0});
        step(1'b0);
        check("sat_sh_strb", 32'(strobes3()), 32'b10_0110_0000);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0);
            check("sat_w3", 32'(shift_cnt3), (i > 7) ? 32'd7 : 32'(i));
            check("sat_w8", 32'(shift_cnt), 32'(i));
        end
        check("sat_state3", 32'(state3), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
